// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add multiplier, signed/unsigned per operation
// Optional EARLY_TERM_EN: leave RUN as soon as the unconsumed multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     mcand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0]   LAST_C = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P  = (2*WIDTH)'(1);

  logic [2:0]         state;
  logic [WIDTH-1:0]   lat_mplier;
  logic [WIDTH-1:0]   lat_mcand;
  logic               sgn;
  logic               neg;
  logic [WIDTH:0]     acc_a;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   op_b;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  assign sum  = {1'b0, acc_a[WIDTH-1:0]} + {1'b0, op_b};
  assign raw  = {acc_a[WIDTH-1:0], acc_q};
  assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

`ifdef EARLY_TERM_EN
  localparam logic [CNT_W-1:0] W_C  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [CNT_W-1:0]   rem;
  logic               q_empty;
  logic [2*WIDTH:0]   shifted;

  // Unconsumed multiplier bits sit in the low WIDTH-cnt bits of Q.
  assign rem     = W_C - cnt;
  assign q_empty = (acc_q & (ONES >> cnt)) == '0;
  assign shifted = {acc_a, acc_q} >> rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lat_mplier <= '0;
      lat_mcand  <= '0;
      sgn        <= 1'b0;
      neg        <= 1'b0;
      acc_a      <= '0;
      acc_q      <= '0;
      op_b       <= '0;
      cnt        <= '0;
      product    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_mplier <= mplier;
            lat_mcand  <= mcand;
            sgn        <= signed_mode;
            // A zero operand never produces a negated result.
            neg        <= signed_mode & (mplier[WIDTH-1] ^ mcand[WIDTH-1])
                          & (|mplier) & (|mcand);
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_a <= '0;
          acc_q <= mag(lat_mplier, sgn);
          op_b  <= mag(lat_mcand, sgn);
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
`ifdef EARLY_TERM_EN
          if (q_empty) begin
            {acc_a, acc_q} <= shifted;
            state          <= S_FIX;
          end else
`endif
          begin
            if (acc_q[0]) begin
              acc_a <= {1'b0, sum[WIDTH:1]};
              acc_q <= {sum[0], acc_q[WIDTH-1:1]};
            end else begin
              acc_a <= {1'b0, acc_a[WIDTH:1]};
              acc_q <= {acc_a[0], acc_q[WIDTH-1:1]};
            end
            cnt <= cnt + ONE_C;
            if (cnt == LAST_C) state <= S_FIX;
          end
        end
        S_FIX: begin
          product <= neg ? (~raw + ONE_P) : raw;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier (WIDTH=16 and WIDTH=4)
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] p16;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb16[$];
  logic [7:0]  sb4[$];

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(16)) u_mul16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .mplier(a16), .mcand(b16), .busy(busy16), .done(done16), .product(p16)
  );

  shift_add_multiplier #(.WIDTH(4)) u_mul4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .mplier(a4), .mcand(b4), .busy(busy4), .done(done4), .product(p4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint ea, eb;
    ea = (sm && a[15]) ? longint'(a) - 65536 : longint'(a);
    eb = (sm && b[15]) ? longint'(b) - 65536 : longint'(b);
    return 32'(ea * eb);
  endfunction

  function automatic logic [7:0] model4(input logic sm, input logic [3:0] a, input logic [3:0] b);
    int ea, eb;
    ea = (sm && a[3]) ? int'(a) - 16 : int'(a);
    eb = (sm && b[3]) ? int'(b) - 16 : int'(b);
    return 8'(ea * eb);
  endfunction

  // Edges from the sampling edge (counted as 1) until done is seen.
  function automatic int exp_lat16(input logic sm, input logic [15:0] a);
`ifdef EARLY_TERM_EN
    logic [15:0] m;
    int idx;
    m   = (sm && a[15]) ? 16'(0 - int'(a)) : a;
    idx = -1;
    for (int i = 0; i < 16; i++) if (m[i]) idx = i;
    return (idx + 5 > 19) ? 19 : idx + 5;
`else
    return 19 + 0 * int'({sm, a});
`endif
  endfunction

  task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                      input int hold, input bit scramble);
    int lat, bcnt;
    logic [31:0] exp;
    sb16.push_back(model16(sm, a, b));
    @(negedge clk);
    sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy16) bcnt++;
      if (scramble && lat == 5) begin
        a16 = ~a; b16 = b + 16'd7; sm16 = ~sm;
      end
    end while (!done16 && lat < 100);
    check("op16_done", done16, 1);
    check("op16_latency", lat, exp_lat16(sm, a));
    check("op16_busy_cycles", bcnt, exp_lat16(sm, a) - 1);
    if (sb16.size() == 0) check("op16_sb_empty", 1, 0);
    else begin
      exp = sb16.pop_front();
      check("op16_product", p16, exp);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("op16_hold_done", done16, 1);
        check("op16_hold_busy", busy16, 0);
        check("op16_hold_product", p16, exp);
      end
    end
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    check("op16_idle_done", done16, 0);
    check("op16_idle_busy", busy16, 0);
  endtask

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b);
    int n;
    logic [7:0] exp;
    sb4.push_back(model4(sm, a, b));
    @(negedge clk);
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done4 && n < 50);
    check("op4_done", done4, 1);
    if (sb4.size() == 0) check("op4_sb_empty", 1, 0);
    else begin
      exp = sb4.pop_front();
      check("op4_product", p4, exp);
      @(posedge clk); #1;
      check("op4_stable", p4, exp);
    end
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_product", p16, 0);
    check("rst_product4", p4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op16(1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    check("t1_const", p16, 32'hFFFE0001);
    op16(1'b1, 16'h8000, 16'h8000, 0, 1'b0);
    check("t2_minmin", p16, 32'h40000000);
    op16(1'b1, 16'hFFFD, 16'h0005, 0, 1'b0);
    check("t2_neg3x5", p16, 32'hFFFFFFF1);
    op16(1'b1, 16'h0000, 16'h8000, 0, 1'b0);
    check("zero_signed", p16, 32'h0);
    op16(1'b0, 16'h0003, 16'h1234, 0, 1'b0);
    check("t6_3x1234", p16, 32'h0000369C);

    // Start held in DONE, then operands disturbed mid-RUN.
    op16(1'b1, 16'h1234, 16'hF00F, 10, 1'b0);
    op16(1'b1, 16'h8001, 16'h7FFF, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0, 1'b0);

    // Reset during RUN.
    @(negedge clk);
    sm16 = 1'b0; a16 = 16'hABCD; b16 = 16'h1357; start16 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrun_busy", busy16, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy16, 0);
    check("midrun_rst_done", done16, 0);
    check("midrun_rst_product", p16, 0);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op16(1'b1, 16'h7FFF, 16'h8000, 0, 1'b0);

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(1'(m), 4'(a), 4'(b));

    check("sb16_drained", sb16.size(), 0);
    check("sb4_drained", sb4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
